// File: rtl/layeriomem_dfifo_drain.sv
// layeriomem_dfifo_drain: round-robin drain of per-bank dfifos into layerio banks and address memory.
// Defining LAYERIOMEM_DRAIN_CHECK_EN adds the sticky overflow_err_o output.
module layeriomem_dfifo_drain #(
    parameter  int CLKDIV = 4,
    parameter  int DEPTH  = 4096,
    parameter  int DATA_W = 128,
    parameter  int CNT_W  = 32,
    localparam int AW     = $clog2(DEPTH),
    localparam int BW     = $clog2(DEPTH / CLKDIV),
    localparam int GW     = $clog2(CLKDIV),
    localparam int EW     = AW + BW + DATA_W
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [CLKDIV-1:0]    dfifo_empty_i,
    input  logic [CLKDIV*EW-1:0] dfifo_q_i,
    output logic [CLKDIV-1:0]    dfifo_rdreq_o,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     total_layerio_writes_i,
    input  logic [BW-1:0]        wr_offset_i,
    output logic [CLKDIV-1:0]    bank_we_o,
    output logic [BW-1:0]        bank_addr_o,
    output logic [DATA_W-1:0]    bank_d_o,
    output logic                 amem_we_o,
    output logic [AW-1:0]        amem_addr_o,
    output logic [GW+BW-1:0]     amem_d_o,
    output logic                 wrote_layerio_layer_o,
`ifdef LAYERIOMEM_DRAIN_CHECK_EN
    output logic [CNT_W-1:0]     writes_done_o,
    output logic                 overflow_err_o
`else
    output logic [CNT_W-1:0]     writes_done_o
`endif
);
    logic [GW-1:0]     ptr_q, g;
    logic              gnt, done;
    logic [EW-1:0]     ent;
    logic [AW-1:0]     ent_a;
    logic [BW-1:0]     baddr;
    logic [CNT_W-1:0]  cnt_q, cnt_d, base, inc;
    logic [CLKDIV-1:0] bank_we_q;
    logic [BW-1:0]     bank_addr_q;
    logic [DATA_W-1:0] bank_d_q;
    logic              amem_we_q, pulse_q;
    logic [AW-1:0]     amem_addr_q;
    logic [GW+BW-1:0]  amem_d_q;

    // Descending scan so the closest non-empty fifo at/after ptr wins.
    always_comb begin
        g   = '0;
        gnt = 1'b0;
        for (int k = CLKDIV - 1; k >= 0; k--) begin
            if (!dfifo_empty_i[ptr_q + GW'(k)]) begin
                g   = ptr_q + GW'(k);
                gnt = 1'b1;
            end
        end
    end

    assign dfifo_rdreq_o = (gnt && !reset_i) ? CLKDIV'(1) << g : '0;
    assign ent   = dfifo_q_i[g*EW +: EW];
    assign ent_a = ent[EW-1 -: AW];
    assign baddr = ent[DATA_W +: BW] + wr_offset_i;

    // A pop in the start cycle counts toward the new layer; the count saturates.
    assign base  = start_i ? '0 : cnt_q;
    assign inc   = &base ? base : base + CNT_W'(1);
    assign done  = gnt && total_layerio_writes_i != '0 && inc == total_layerio_writes_i;
    assign cnt_d = !gnt ? base : done ? '0 : inc;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
            bank_we_q   <= '0;
            bank_addr_q <= '0;
            bank_d_q    <= '0;
            amem_we_q   <= 1'b0;
            amem_addr_q <= '0;
            amem_d_q    <= '0;
        end else begin
            ptr_q     <= gnt ? g + GW'(1) : ptr_q;
            cnt_q     <= cnt_d;
            pulse_q   <= done;
            bank_we_q <= gnt ? CLKDIV'(1) << g : '0;
            amem_we_q <= gnt;
            if (gnt) begin
                bank_addr_q <= baddr;
                bank_d_q    <= ent[DATA_W-1:0];
                amem_addr_q <= ent_a;
                amem_d_q    <= {g, baddr};
            end
        end
    end

`ifdef LAYERIOMEM_DRAIN_CHECK_EN
    logic ovf_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) ovf_q <= 1'b0;
        else ovf_q <= ovf_q | (gnt && ((cnt_q == total_layerio_writes_i && total_layerio_writes_i != '0)
                                       || 32'(ent_a) >= DEPTH));
    end
    assign overflow_err_o = ovf_q;
`endif

    assign bank_we_o             = bank_we_q;
    assign bank_addr_o           = bank_addr_q;
    assign bank_d_o              = bank_d_q;
    assign amem_we_o             = amem_we_q;
    assign amem_addr_o           = amem_addr_q;
    assign amem_d_o              = amem_d_q;
    assign wrote_layerio_layer_o = pulse_q;
    assign writes_done_o         = cnt_q;
endmodule
